// File: rtl/ysyx_25020037_axi_rd_arb.sv
// ysyx_25020037_axi_rd_arb: two-master (m0 IFU, m1 LSU) to one-slave AXI4 read-channel arbiter.
// Ports: clk/rst; m0_* and m1_* upstream AR/R channels; s_* downstream AR/R channel;
// grant = current owner (0 IFU, 1 LSU, valid while busy); busy = transaction in progress.
module ysyx_25020037_axi_rd_arb #(
  parameter logic        RR_EN   = 1'b0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,
  output logic [3:0]  m0_rid,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,
  output logic [3:0]  m1_rid,
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rlast,
  input  logic [3:0]  s_rid,
  output logic        grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ABORT} state_t;
  state_t      state_q, state_d;
  logic        grant_q, grant_d, last_grant_q, last_grant_d;
  logic [31:0] cnt_q, cnt_d;
  logic        in_addr, in_data, in_abort, sel0, sel1, g_arvalid, g_rready, r_hs;
  assign in_addr   = state_q == ADDR;
  assign in_data   = state_q == DATA;
  assign in_abort  = state_q == ABORT;
  assign sel0      = !grant_q;
  assign sel1      = grant_q;
  assign g_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant_q ? m1_rready : m0_rready;
  assign r_hs      = in_data && s_rvalid && g_rready;
  assign grant     = grant_q;
  assign busy      = state_q != IDLE;
  assign s_arvalid = in_addr && g_arvalid;
  assign s_araddr  = grant_q ? m1_araddr : m0_araddr;
  assign s_arid    = grant_q ? m1_arid : m0_arid;
  assign s_arlen   = grant_q ? m1_arlen : m0_arlen;
  assign s_arsize  = grant_q ? m1_arsize : m0_arsize;
  assign s_arburst = grant_q ? m1_arburst : m0_arburst;
  assign m0_arready = in_addr && sel0 && s_arready;
  assign m1_arready = in_addr && sel1 && s_arready;
  assign s_rready   = in_data && g_rready;
  // ABORT synthesizes a single DECERR last beat for the owner; the slave is not consulted.
  assign m0_rvalid = sel0 && (in_abort || (in_data && s_rvalid));
  assign m0_rdata  = (sel0 && in_data) ? s_rdata : '0;
  assign m0_rresp  = (sel0 && in_data) ? s_rresp : (sel0 && in_abort) ? 2'b11 : 2'b00;
  assign m0_rlast  = sel0 && (in_abort || (in_data && s_rlast));
  assign m0_rid    = (sel0 && in_data) ? s_rid : '0;
  assign m1_rvalid = sel1 && (in_abort || (in_data && s_rvalid));
  assign m1_rdata  = (sel1 && in_data) ? s_rdata : '0;
  assign m1_rresp  = (sel1 && in_data) ? s_rresp : (sel1 && in_abort) ? 2'b11 : 2'b00;
  assign m1_rlast  = sel1 && (in_abort || (in_data && s_rlast));
  assign m1_rid    = (sel1 && in_data) ? s_rid : '0;
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = '0;
    case (state_q)
      IDLE: if (m0_arvalid || m1_arvalid) begin
        state_d = ADDR;
        // On a tie, round-robin favours whoever was not served last; fixed mode favours the LSU.
        grant_d = (m0_arvalid && m1_arvalid) ? (RR_EN ? !last_grant_q : 1'b1) : m1_arvalid;
      end
      ADDR: if (!g_arvalid) state_d = IDLE;
        else if (s_arready) begin
          state_d      = DATA;
          last_grant_d = grant_q;
        end
      DATA: if (r_hs) state_d = s_rlast ? IDLE : DATA;
        else if (TIMEOUT != 0 && cnt_q + 32'd1 == TIMEOUT) state_d = ABORT;
        else cnt_d = cnt_q + 32'd1;
      ABORT: if (g_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule
